// File: rtl/alu_exec_unit.sv
// ALU execute unit: registered single-cycle integer ops plus optional iterative mult/div with HI/LO.
// Define ALU_MULDIV_EN to build the MUL/DIV sequencer and the HI/LO registers.
//   state | meaning
//   IDLE  | ready; single-cycle ops complete on the acceptance edge
//   MUL   | shift-add on operand magnitudes, one multiplier bit per cycle
//   DIV   | restoring divide on magnitudes, one quotient bit per cycle
//   FIX   | sign correction, HI/LO write, out_valid
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       ALUop,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             illegal,
  output logic             out_valid,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, ovf_q, ovf_d;
  logic             illegal_q, illegal_d, out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum, diff, sc_res;
  logic             add_ovf, sub_ovf, sc_ovf, sc_ill, accept;

  assign sum     = a + b;
  assign diff    = a - b;
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

`ifdef ALU_MULDIV_EN
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, prod_fix;
  logic [WIDTH-1:0]   opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d;
  logic               neg_res_q, neg_res_d, neg_rem_q, neg_rem_d, is_div_q, is_div_d;
  logic               op_mul, op_div, op_sgn;
  logic [WIDTH-1:0]   mag_a, mag_b, quo_fix, rem_fix, hi_fix, lo_fix;
  logic [WIDTH:0]     mul_sum, div_shift, div_trial;

  assign busy  = (state_q != IDLE);
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign mag_a = (op_sgn && a[WIDTH-1]) ? -a : a;
  assign mag_b = (op_sgn && b[WIDTH-1]) ? -b : b;

  // acc_q holds the partial product, or {remainder, dividend/quotient} when dividing
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opnd_q};

  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  assign hi_fix   = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
  assign lo_fix   = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
`else
  assign busy = 1'b0;
  assign hi   = '0;
  assign lo   = '0;
`endif

  assign in_ready = !busy;
  assign accept   = in_valid && in_ready;

  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    sc_ill = 1'b0;
`ifdef ALU_MULDIV_EN
    op_mul = 1'b0;
    op_div = 1'b0;
    op_sgn = 1'b0;
`endif
    case (ALUop)
      2'b00: begin sc_res = sum;  sc_ovf = add_ovf; end
      2'b01: begin sc_res = diff; sc_ovf = sub_ovf; end
      2'b11: sc_res = a & b;
      default: begin
        case (funct)
          6'b100000: begin sc_res = sum;  sc_ovf = add_ovf; end
          6'b100001: sc_res = sum;
          6'b100010: begin sc_res = diff; sc_ovf = sub_ovf; end
          6'b100011: sc_res = diff;
          6'b100100: sc_res = a & b;
          6'b100101: sc_res = a | b;
          6'b100110: sc_res = a ^ b;
          6'b100111: sc_res = ~(a | b);
          6'b101010: sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
          6'b101011: sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
`ifdef ALU_MULDIV_EN
          6'b010000: sc_res = hi_q;
          6'b010010: sc_res = lo_q;
          6'b011000: begin op_mul = 1'b1; op_sgn = 1'b1; end
          6'b011001: op_mul = 1'b1;
          6'b011010: begin op_div = 1'b1; op_sgn = 1'b1; end
          6'b011011: op_div = 1'b1;
`endif
          default:   sc_ill = 1'b1;
        endcase
      end
    endcase
  end

  always_comb begin
    result_d    = result_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    illegal_d   = illegal_q;
    out_valid_d = 1'b0;
`ifdef ALU_MULDIV_EN
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    is_div_d  = is_div_q;
`endif
    if (accept) begin
`ifdef ALU_MULDIV_EN
      if (op_mul) begin
        state_d   = MUL;
        cnt_d     = CW'(WIDTH);
        acc_d     = {{WIDTH{1'b0}}, mag_b};
        opnd_d    = mag_a;
        neg_res_d = op_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
        is_div_d  = 1'b0;
      end else if (op_div && (b != '0)) begin
        state_d   = DIV;
        cnt_d     = CW'(WIDTH);
        acc_d     = {{WIDTH{1'b0}}, mag_a};
        opnd_d    = mag_b;
        neg_res_d = op_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_rem_d = op_sgn && a[WIDTH-1];
        is_div_d  = 1'b1;
      end else if (op_div) begin
        // divide by zero completes immediately with a fixed, non-trapping answer
        out_valid_d = 1'b1;
        lo_d        = '1;
        hi_d        = a;
        result_d    = '1;
        zero_d      = 1'b0;
        ovf_d       = 1'b0;
        illegal_d   = 1'b0;
      end else
`endif
      begin
        out_valid_d = 1'b1;
        result_d    = sc_res;
        zero_d      = (sc_res == '0);
        ovf_d       = sc_ovf;
        illegal_d   = sc_ill;
      end
    end
`ifdef ALU_MULDIV_EN
    case (state_q)
      MUL: begin
        if (cnt_q == '0) state_d = FIX;
        else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          cnt_d = cnt_q - CW'(1);
        end
      end
      DIV: begin
        if (cnt_q == '0) state_d = FIX;
        else begin
          if (!div_trial[WIDTH]) acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else                   acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          cnt_d = cnt_q - CW'(1);
        end
      end
      FIX: begin
        state_d     = IDLE;
        hi_d        = hi_fix;
        lo_d        = lo_fix;
        out_valid_d = 1'b1;
        result_d    = lo_fix;
        zero_d      = (lo_fix == '0);
        ovf_d       = 1'b0;
        illegal_d   = 1'b0;
      end
      default: ;
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef ALU_MULDIV_EN
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
`endif
    end else begin
      result_q    <= result_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
`ifdef ALU_MULDIV_EN
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      is_div_q  <= is_div_d;
`endif
    end
  end

  assign result    = result_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign illegal   = illegal_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit (WIDTH=32); the mult/div section is built only with ALU_MULDIV_EN.
module tb_alu_exec_unit;
  logic        clk, reset, in_valid, in_ready, zero, ovf, illegal, out_valid, busy;
  logic [1:0]  ALUop;
  logic [5:0]  funct;
  logic [31:0] a, b, result, hi, lo;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc, bcnt, ov_seen;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .ALUop(ALUop), .funct(funct), .a(a), .b(b),
    .in_valid(in_valid), .in_ready(in_ready), .result(result), .zero(zero), .ovf(ovf),
    .illegal(illegal), .out_valid(out_valid), .busy(busy), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // present one request for exactly one edge; returns 1 time unit after that edge
  task automatic issue(input logic [1:0] op, input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    ALUop = op; funct = f; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n, output int nb);
    n  = 0;
    nb = busy ? 1 : 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (busy) nb++;
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; ALUop = 2'b00; funct = 6'd0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {zero, ovf, illegal, busy}, 4'b0000);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_hilo", {hi, lo}, 64'd0);
    @(negedge clk); reset = 1'b0;

    issue(2'b10, 6'b100000, 32'd5, 32'd7);
    chk("add_valid", out_valid, 1);
    chk("add_result", result, 32'd12);
    chk("add_flags", {zero, ovf, illegal}, 3'b000);
    @(posedge clk); #1;
    chk("pulse_one_cycle", out_valid, 0);

    issue(2'b01, 6'd0, 32'd7, 32'd7);
    chk("sub_zero", {result, 31'd0, zero}, {32'd0, 32'd1});
    issue(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1);
    chk("slt_neg", result, 32'd1);
    issue(2'b10, 6'b101011, 32'hFFFF_FFFF, 32'd1);
    chk("sltu", {result, 31'd0, zero}, {32'd0, 32'd1});
    issue(2'b00, 6'd0, 32'h7FFF_FFFF, 32'd1);
    chk("add_ovf", {result, 31'd0, ovf}, {32'h8000_0000, 32'd1});
    issue(2'b10, 6'b100001, 32'h7FFF_FFFF, 32'd1);
    chk("addu_no_ovf", {result, 31'd0, ovf}, {32'h8000_0000, 32'd0});
    issue(2'b10, 6'b100010, 32'h8000_0000, 32'd1);
    chk("sub_ovf", {result, 31'd0, ovf}, {32'h7FFF_FFFF, 32'd1});
    issue(2'b10, 6'b100011, 32'd3, 32'd5);
    chk("subu_wrap", {result, 31'd0, ovf}, {32'hFFFF_FFFE, 32'd0});
    issue(2'b11, 6'b100000, 32'hF0F0_1234, 32'h0FF0_FF00);
    chk("aluop_and", result, 32'h00F0_1200);
    issue(2'b10, 6'b100101, 32'hF000_000F, 32'h0F00_00F0);
    chk("or", result, 32'hFF00_00FF);
    issue(2'b10, 6'b100110, 32'hFFFF_0000, 32'hFF00_FF00);
    chk("xor", result, 32'h00FF_FF00);
    issue(2'b10, 6'b100111, 32'hFFFF_0000, 32'h0000_FF00);
    chk("nor", result, 32'h0000_00FF);
    issue(2'b10, 6'b101010, 32'd3, 32'hFFFF_FFFE);
    chk("slt_pos_vs_neg", {result, 31'd0, zero}, {32'd0, 32'd1});
    issue(2'b10, 6'b111111, 32'd9, 32'd9);
    chk("illegal_funct", {result, 29'd0, illegal, ovf, out_valid}, {32'd0, 32'd5});

    // back-to-back acceptance
    issue(2'b00, 6'd0, 32'd1, 32'd2);
    chk("b2b_first", {result, 31'd0, out_valid}, {32'd3, 32'd1});
    issue(2'b01, 6'd0, 32'd10, 32'd3);
    chk("b2b_second", {result, 31'd0, out_valid}, {32'd7, 32'd1});

    // reset wins over a simultaneous request
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; ALUop = 2'b00; a = 32'd4; b = 32'd4;
    @(posedge clk); #1;
    chk("rst_priority", {result, 31'd0, out_valid}, {32'd0, 32'd0});
    @(negedge clk); reset = 1'b0; in_valid = 1'b0;

`ifdef ALU_MULDIV_EN
    issue(2'b10, 6'b011000, 32'hFFFF_FFFD, 32'd5);
    chk("mult_busy_start", {busy, in_ready, out_valid}, 3'b100);
    ALUop = 2'b00; a = 32'd1; b = 32'd1; in_valid = 1'b1;
    wait_done(cyc, bcnt);
    chk("mult_latency", cyc, 34);
    chk("mult_busy_cycles", bcnt, 34);
    chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    chk("mult_result", {result, 30'd0, zero, ovf}, {32'hFFFF_FFF1, 32'd0});
    ALUop = 2'b00; a = 32'd1; b = 32'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("accept_on_done", {result, 31'd0, out_valid}, {32'd2, 32'd1});
    issue(2'b10, 6'b010000, 32'd0, 32'd0);
    chk("mfhi", result, 32'hFFFF_FFFF);
    issue(2'b10, 6'b010010, 32'd0, 32'd0);
    chk("mflo", result, 32'hFFFF_FFF1);

    issue(2'b10, 6'b011001, 32'hFFFF_FFFF, 32'd2);
    wait_done(cyc, bcnt);
    chk("multu_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    issue(2'b10, 6'b011010, 32'hFFFF_FFF9, 32'd2);
    wait_done(cyc, bcnt);
    chk("div_latency", cyc, 34);
    chk("div_neg_dividend", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(2'b10, 6'b011010, 32'd7, 32'hFFFF_FFFE);
    wait_done(cyc, bcnt);
    chk("div_neg_divisor", {hi, lo}, 64'h0000_0001_FFFF_FFFD);
    issue(2'b10, 6'b011011, 32'd100, 32'd7);
    wait_done(cyc, bcnt);
    chk("divu", {hi, lo}, 64'h0000_0002_0000_000E);
    issue(2'b10, 6'b011011, 32'd9, 32'd0);
    chk("div0_timing", {out_valid, busy, illegal}, 3'b100);
    chk("div0_hilo", {hi, lo}, 64'h0000_0009_FFFF_FFFF);

    issue(2'b10, 6'b011000, 32'd3, 32'd4);
    repeat (9) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_state", {busy, out_valid}, 2'b00);
    chk("abort_hilo", {hi, lo}, 64'd0);
    @(negedge clk); reset = 1'b0;
    ov_seen = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (out_valid) ov_seen++;
    end
    chk("abort_no_valid", ov_seen, 0);
`else
    issue(2'b10, 6'b011000, 32'd3, 32'd4);
    chk("mult_disabled", {result, 29'd0, out_valid, illegal, busy}, {32'd0, 32'd6});
    chk("mult_disabled_ready", in_ready, 1);
    issue(2'b10, 6'b011010, 32'd9, 32'd0);
    chk("div_disabled", {result, 30'd0, illegal, ovf}, {32'd0, 32'd2});
    issue(2'b10, 6'b010000, 32'd0, 32'd0);
    chk("mfhi_disabled", {result, 31'd0, illegal}, {32'd0, 32'd1});
    chk("hilo_tied", {hi, lo}, 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal 8..64).
REQ-002 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-003 reset  in  1  reset, synchronous and active-high.
REQ-004 ALUop  in  2  main-decoder class (00 add, 01 sub, 10 funct-decoded, 11 and).
REQ-005 funct  in  6  R-type function field, used only when ALUop=10.
REQ-006 a, b  in  WIDTH  operands; in_valid  in  1  request strobe; in_ready  out  1  high when state=IDLE.
REQ-007 result  out  WIDTH; zero  out  1 (result==0); ovf  out  1 signed overflow; illegal  out  1 undecodable funct.
REQ-008 out_valid  out  1  one-cycle pulse qualifying result/zero/ovf/illegal; busy  out  1  multi-cycle op in flight.
REQ-009 hi, lo  out  WIDTH  architectural HI/LO registers.

Function
REQ-010 Request SHALL be accepted on an edge where in_valid=1 and in_ready=1; otherwise in_valid is ignored.
REQ-011 Decode: ALUop 00 add; 01 sub; 11 and; 10 by funct: 100000 add, 100001 addu, 100010 sub, 100011 subu, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt (signed), 101011 sltu, 010000 mfhi, 010010 mflo, 011000 mult, 011001 multu, 011010 div, 011011 divu.
REQ-012 Single-cycle ops (all except mult/multu/div/divu) SHALL register outputs on the acceptance edge; out_valid high the following cycle only; back-to-back acceptance every cycle allowed.
REQ-013 ovf SHALL be set only for add/sub (ALUop 00/01, funct 100000/100010) on two's-complement signed overflow; result still wraps modulo 2^WIDTH.
REQ-014 slt/sltu SHALL produce 1 or 0 zero-extended to WIDTH.
REQ-015 Unlisted funct under ALUop=10 SHALL give result=0, illegal=1, ovf=0, single-cycle timing; hi/lo unchanged.
REQ-016 FSM states IDLE, MUL, DIV, FIX: IDLE->MUL on accepted mult/multu, IDLE->DIV on accepted div/divu with b!=0, MUL/DIV->FIX after exactly WIDTH iteration cycles, FIX->IDLE always.
REQ-017 MUL: shift-add, one bit per cycle on operand magnitudes; DIV: restoring, one quotient bit per cycle on magnitudes; FIX applies sign correction and writes hi/lo.
REQ-018 mult SHALL leave {hi,lo} = 2*WIDTH-bit signed product; multu unsigned product.
REQ-019 div SHALL give lo=quotient truncated toward zero, hi=remainder with sign of dividend; divu unsigned.
REQ-020 Divide by zero SHALL take single-cycle timing: lo=all ones, hi=a, illegal=0.
REQ-021 Multi-cycle out_valid SHALL pulse exactly WIDTH+2 cycles after the acceptance edge (cycle of FIX->IDLE edge +0); result=lo, zero from lo, ovf=0.
REQ-022 busy SHALL be high in MUL, DIV, FIX; in_ready=!busy; a request presented in the cycle out_valid is high SHALL be accepted.
REQ-023 mfhi/mflo SHALL return hi/lo as of the acceptance edge.

Reset
REQ-024 On reset edge: state=IDLE, hi=lo=0, result=0, out_valid=0, zero=0, ovf=0, illegal=0, busy=0.
REQ-025 Reset mid-operation SHALL abort with no out_valid and no hi/lo update; reset has priority over a simultaneous in_valid.

Configuration
REQ-026 Macro ALU_MULDIV_EN: defined SHALL include REQ-016..REQ-021 and HI/LO; undefined SHALL remove FSM and HI/LO, tie hi=lo=0, busy=0, in_ready=1, and treat mult/multu/div/divu/mfhi/mflo as illegal per REQ-015.

Verification (WIDTH=32)
REQ-027 ALUop=10 funct=100000 a=5 b=7 -> next cycle out_valid=1 result=12 zero=0 ovf=0.
REQ-028 ALUop=01 a=7 b=7 -> result=0 zero=1; funct=101010 a=FFFFFFFF b=1 -> result=1; funct=101011 same operands -> result=0; ALUop=00 a=7FFFFFFF b=1 -> result=80000000 ovf=1.
REQ-029 funct=011000 a=FFFFFFFD b=5 -> busy 34 cycles, in_valid ignored meanwhile, out_valid at cycle 34, hi=FFFFFFFF lo=FFFFFFF1; then funct=010000 -> result=FFFFFFFF.
REQ-030 funct=011010 a=FFFFFFF9 b=2 -> lo=FFFFFFFD hi=FFFFFFFF; funct=011011 a=9 b=0 -> next cycle out_valid, lo=FFFFFFFF hi=9.
REQ-031 reset asserted 10 cycles into a mult -> next cycle busy=0 hi=lo=0, no out_valid thereafter.
REQ-032 Built without ALU_MULDIV_EN: funct=011000 a=3 b=4 -> next cycle out_valid=1 illegal=1 result=0 busy=0.
